// File: rtl/sme_pkg.sv
// Shared types and constants for the SME match extractor.
package sme_pkg;

  localparam int SME_LANES   = 32;
  localparam int SME_BUCKETS = 8;
  localparam int SME_OFF_W   = 16;

  typedef struct packed {
    logic                 is_match;
    logic                 eop;
    logic [SME_OFF_W-1:0] offset;
    logic [2:0]           bucket;
  } sme_match_rec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    TERM = 2'd2
  } sme_ext_state_e;

endpackage

// File: rtl/sme_word_fifo.sv
// Word buffer between the filter and the extractor; a push into a full
// buffer still lands when a pop frees a slot in the same cycle.
module sme_word_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_drop    = i_push && !w_do_push;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // When full, read and write hit the same slot; the read sees the old word.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/sme_match_extractor.sv
// Turns shift-or filter words into one {offset, bucket} record per match,
// closing each packet with a length terminator.
module sme_match_extractor #(
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int OFF_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_match,
  output logic [OFF_W-1:0]  out_offset,
  output logic [2:0]        out_bucket,
  output logic              out_eop,
  output logic              drop_err
);

  import sme_pkg::*;

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);
  localparam int WCNT_W = OFF_W - LANE_W;
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int BKT_W  = $clog2(SME_BUCKETS);

  sme_ext_state_e    r_state;
  sme_ext_state_e    w_state_nxt;
  logic [DATA_W-1:0] r_pend;
  logic              r_last;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_drop_err;

  logic [DATA_W:0]   w_fifo_data;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic              w_pop;
  logic              w_wcnt_inc;
  logic              w_wcnt_clr;
  logic              w_accept;
  logic [BIT_W-1:0]  w_low_idx;
  logic [OFF_W:0]    w_word_base;
  logic [OFF_W:0]    w_match_sum;
  logic [OFF_W:0]    w_term_sum;
  logic [OFF_W-1:0]  w_match_off;
  logic [OFF_W-1:0]  w_term_off;

  sme_word_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_pop   (w_pop),
    .i_data  ({in_last, in_data}),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  // Lowest set bit of the pending mask; scanning downward lets the lowest win.
  always_comb begin
    w_low_idx = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (r_pend[i]) w_low_idx = BIT_W'(i);
    end
  end

  // One spare MSB catches overflow so offsets clamp at all-ones instead of wrapping.
  assign w_word_base = {1'b0, r_wcnt, {LANE_W{1'b0}}};
  assign w_match_sum = w_word_base + {{(OFF_W + 1 - LANE_W){1'b0}}, w_low_idx[BIT_W-1:BKT_W]};
  assign w_term_sum  = w_word_base + (OFF_W + 1)'(LANES);
  assign w_match_off = w_match_sum[OFF_W] ? '1 : w_match_sum[OFF_W-1:0];
  assign w_term_off  = w_term_sum[OFF_W]  ? '1 : w_term_sum[OFF_W-1:0];
  assign w_accept    = out_valid && out_ready;
  assign drop_err    = r_drop_err;

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_wcnt_inc   = 1'b0;
    w_wcnt_clr   = 1'b0;
    out_valid    = 1'b0;
    out_is_match = 1'b0;
    out_eop      = 1'b0;
    out_offset   = '0;
    out_bucket   = '0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (|r_pend) begin
          out_valid    = 1'b1;
          out_is_match = 1'b1;
          out_offset   = w_match_off;
          out_bucket   = w_low_idx[BKT_W-1:0];
        end else if (r_last) begin
          w_state_nxt = TERM;
        end else begin
          w_wcnt_inc = 1'b1;
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nxt = IDLE;
        end
      end
      TERM: begin
        out_valid  = 1'b1;
        out_eop    = 1'b1;
        out_offset = w_term_off;
        if (out_ready) begin
          w_wcnt_clr  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_last     <= 1'b0;
      r_wcnt     <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_pend <= ~w_fifo_data[DATA_W-1:0];
        r_last <= w_fifo_data[DATA_W];
      end else if (r_state == SCAN && w_accept) begin
        r_pend <= r_pend & (r_pend - 1'b1);
      end
      if (w_wcnt_clr) begin
        r_wcnt <= '0;
      end else if (w_wcnt_inc && (r_wcnt != '1)) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
      if (w_drop) r_drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sme_match_extractor.sv
// Directed bench for sme_match_extractor: vector table plus corner sequences.
module tb_sme_match_extractor;
  import sme_pkg::*;

  localparam int DW = 256;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_is_match;
  logic [OW-1:0] out_offset;
  logic [2:0]    out_bucket;
  logic          out_eop;
  logic          drop_err;

  always #5 clk = ~clk;

  sme_match_extractor #(.DATA_W(DW), .FIFO_DEPTH(16), .OFF_W(OW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_is_match (out_is_match),
    .out_offset   (out_offset),
    .out_bucket   (out_bucket),
    .out_eop      (out_eop),
    .drop_err     (drop_err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  sme_match_rec_t rx[$];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      rx.push_back({out_is_match, out_eop, out_offset, out_bucket});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic sme_match_rec_t mk(input bit m, input bit e, input int off, input int b);
    return {m, e, OW'(off), 3'(b)};
  endfunction

  function automatic sme_match_rec_t get(input int i);
    if (i < rx.size()) return rx[i];
    return '1;
  endfunction

  task automatic push_word(input logic [DW-1:0] d, input logic last);
    in_data = d; in_valid = 1'b1; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int c = 0;
    while (rx.size() < n && c < budget) begin
      @(posedge clk); #1; c++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk({name, " record count"}, rx.size(), n);
  endtask

  typedef struct {
    int             nw;
    int             hw;
    int             hb;
    sme_match_rec_t em;
    sme_match_rec_t et;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [DW-1:0]  d;
    sme_match_rec_t snap;
    logic           prev_stall;
    bit             pat [4];

    vt[0] = '{1, 0, 8,   mk(1, 0, 1, 0),   mk(0, 1, 32, 0)};
    vt[1] = '{2, 1, 7,   mk(1, 0, 32, 7),  mk(0, 1, 64, 0)};
    vt[2] = '{3, 1, 255, mk(1, 0, 63, 7),  mk(0, 1, 96, 0)};
    vt[3] = '{1, 0, 100, mk(1, 0, 12, 4),  mk(0, 1, 32, 0)};
    vt[4] = '{4, 3, 131, mk(1, 0, 112, 3), mk(0, 1, 128, 0)};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_fields", {out_is_match, out_eop, out_offset, out_bucket}, 0);
    chk("reset drop_err", drop_err, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1-word packet, bits 0 and 17 matching; also checks first-record latency
    rx.delete();
    d = '1; d[0] = 1'b0; d[17] = 1'b0;
    push_word(d, 1'b1);
    @(negedge clk);
    chk("t1 valid on pop cycle", out_valid, 0);
    @(negedge clk);
    chk("t1 valid one cycle after pop", out_valid, 1);
    @(posedge clk); #1;
    wait_rx(3, 50, "t1");
    chk("t1 rec0", get(0), mk(1, 0, 0, 0));
    chk("t1 rec1", get(1), mk(1, 0, 2, 1));
    chk("t1 term", get(2), mk(0, 1, 32, 0));

    for (int v = 0; v < 5; v++) begin
      rx.delete();
      for (int w = 0; w < vt[v].nw; w++) begin
        d = '1;
        if (w == vt[v].hw) d[vt[v].hb] = 1'b0;
        push_word(d, w == vt[v].nw - 1);
      end
      wait_rx(2, 200, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d match", v), get(0), vt[v].em);
      chk($sformatf("vec%0d term", v), get(1), vt[v].et);
    end

    // Stalling downstream: fields must hold while valid && !ready
    rx.delete();
    out_ready = 1'b0;
    d = '1; d[0] = 1'b0; d[17] = 1'b0;
    push_word(d, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    prev_stall = 1'b0;
    snap = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      out_ready = pat[i % 4];
      @(negedge clk);
      if (prev_stall) begin
        chk($sformatf("t3 hold valid %0d", i), out_valid, 1);
        chk($sformatf("t3 hold fields %0d", i),
            {out_is_match, out_eop, out_offset, out_bucket}, snap);
      end
      prev_stall = out_valid && !out_ready;
      snap = {out_is_match, out_eop, out_offset, out_bucket};
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_rx(3, 50, "t3");
    chk("t3 rec0", get(0), mk(1, 0, 0, 0));
    chk("t3 rec1", get(1), mk(1, 0, 2, 1));
    chk("t3 term", get(2), mk(0, 1, 32, 0));

    // Overflow: one word sits in the scan register, 16 fill the buffer
    rx.delete();
    out_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      push_word('0, 1'b0);
      if (k == 17) chk("t4 drop_err after 17 words", drop_err, 0);
      if (k == 18) chk("t4 drop_err after 18 words", drop_err, 1);
    end
    chk("t4 drop_err sticky", drop_err, 1);
    chk("t4 outputs known", $isunknown({out_valid, out_is_match, out_eop, out_offset, out_bucket}), 0);
    out_ready = 1'b1;
    wait_rx(17 * 256, 6000, "t4");
    chk("t4 first rec", get(0), mk(1, 0, 0, 0));
    chk("t4 last rec", get(17 * 256 - 1), mk(1, 0, 543, 7));
    chk("t4 no terminator", out_valid, 0);

    // Reset while records are pending
    rx.delete();
    out_ready = 1'b0;
    push_word('0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    chk("t5 valid before reset", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5 valid in reset", out_valid, 0);
    chk("t5 drop_err in reset", drop_err, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5 idle after reset", out_valid, 0);
    rx.delete();
    d = '1; d[9] = 1'b0;
    push_word(d, 1'b1);
    wait_rx(2, 50, "t5");
    chk("t5 rec0", get(0), mk(1, 0, 1, 1));
    chk("t5 term", get(1), mk(0, 1, 32, 0));

    // Long packet: word counter and offset must clamp, not wrap
    rx.delete();
    for (int w = 0; w < 2050; w++) begin
      d = '1;
      if (w == 2049) d[255] = 1'b0;
      push_word(d, w == 2049);
    end
    wait_rx(2, 200, "t6");
    chk("t6 saturated match", get(0), mk(1, 0, 16'hFFFF, 7));
    chk("t6 saturated term", get(1), mk(0, 1, 16'hFFFF, 0));
    chk("t6 no drop", drop_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
